// File: rtl/sram_rmw_ctrl.sv
// sram_rmw_ctrl
//   Request/response front-end for a word SRAM with separate read and write
//   strobes and no byte enables. It takes byte-addressed reads and byte-strobed
//   writes from the core. Partial writes become a read-modify-write: the word is
//   read in the accept cycle and written back merged in the following cycle.
//   Only one request is in flight at a time. The response is held in a single
//   registered slot.
//
// Ports
//   clk, reset                   clock (rising edge), synchronous active-high reset
//   req_valid/req_ready          request handshake
//   req_addr                     byte address; [1:0] ignored, upper bits = word address
//   req_wen, req_wstrb, req_wdata  write select, byte strobes, write data
//   resp_valid/resp_ready        response handshake
//   resp_rdata                   read data (0 for write acks)
//   sram_wen/waddr/wdata         SRAM write port
//   sram_ren/raddr, sram_rdata   SRAM read port; rdata is valid the cycle after ren
module sram_rmw_ctrl #(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH+1:0] req_addr,
  input  logic                  req_wen,
  input  logic [3:0]            req_wstrb,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_rdata,
  output logic                  sram_wen,
  output logic [ADDR_WIDTH-1:0] sram_waddr,
  output logic [31:0]           sram_wdata,
  output logic                  sram_ren,
  output logic [ADDR_WIDTH-1:0] sram_raddr,
  input  logic [31:0]           sram_rdata
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_WAIT = 2'd1;
  localparam logic [1:0] RMW_WR  = 2'd2;

  logic [1:0]            state;
  logic                  accept;
  logic                  is_full;
  logic                  is_zero;
  logic                  is_part;
  logic [ADDR_WIDTH-1:0] addr_p1;
  logic [3:0]            strb_p1;
  logic [31:0]           wdata_p1;
  logic                  unused_addr_bits;

  // Byte lanes with a strobe take the new data, the rest keep the old word.
  function automatic logic [31:0] merge_bytes(input logic [3:0]  strb,
                                              input logic [31:0] new_word,
                                              input logic [31:0] old_word);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

  assign unused_addr_bits = ^req_addr[1:0];

  assign req_ready = (state == IDLE) && (!resp_valid || resp_ready);
  assign accept    = req_valid && req_ready;
  assign is_full   = req_wen && (req_wstrb == 4'hF);
  assign is_zero   = req_wen && (req_wstrb == 4'h0);
  assign is_part   = req_wen && !is_full && !is_zero;

  // Stage 0: strobes come straight from the request in the accept cycle.
  // During RMW_WR they come from the latched request merged with SRAM data.
  always_comb begin
    sram_ren   = 1'b0;
    sram_wen   = 1'b0;
    sram_raddr = req_addr[ADDR_WIDTH+1:2];
    sram_waddr = req_addr[ADDR_WIDTH+1:2];
    sram_wdata = req_wdata;
    if (state == RMW_WR) begin
      sram_wen   = 1'b1;
      sram_waddr = addr_p1;
      sram_wdata = merge_bytes(strb_p1, wdata_p1, sram_rdata);
    end else if (state == IDLE && accept) begin
      sram_ren = !req_wen || is_part;
      sram_wen = is_full;
    end
    // Gating the strobes here means a reset in RMW_WR leaves memory untouched.
    if (reset) begin
      sram_ren = 1'b0;
      sram_wen = 1'b0;
    end
  end

  // Stage 1: a partial write's request fields are held for the merge cycle.
  always_ff @(posedge clk) begin
    if (accept && is_part) begin
      addr_p1  <= req_addr[ADDR_WIDTH+1:2];
      strb_p1  <= req_wstrb;
      wdata_p1 <= req_wdata;
    end
  end

  // Control FSM and response slot
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
    end else begin
      // A response that was consumed clears unless a new one loads this edge.
      if (resp_valid && resp_ready) resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (!req_wen) begin
              state <= RD_WAIT;
            end else if (is_part) begin
              state <= RMW_WR;
            end else begin
              resp_valid <= 1'b1;
              resp_rdata <= 32'd0;
            end
          end
        end
        RD_WAIT: begin
          state      <= IDLE;
          resp_valid <= 1'b1;
          resp_rdata <= sram_rdata;
        end
        RMW_WR: begin
          state      <= IDLE;
          resp_valid <= 1'b1;
          resp_rdata <= 32'd0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
